fc_bias_relu: RTL and testbench
===============================

// Module: fc_bias_relu
// PURPOSE
//  Output stage of a fully-connected layer in the digit-recognition datapath.
//  Accepts one signed MAC accumulator per neuron, reads that neuron's 16-bit
//  signed bias from the bias ROM (32x16 pROM, 1-clk read), adds the bias,
//  applies ReLU and saturation, and emits a 16-bit activation downstream.
//  Neuron index is tracked internally, 0..NUM_NEURONS-1 per frame.
// PARAMETERS
//  NUM_NEURONS  30  neurons per frame; ROM entries 0..NUM_NEURONS-1 are used
//  ACC_W        32  signed accumulator width
//  BIAS_SHIFT   0   left shift applied to sign-extended bias (fraction align)
//  OUT_SHIFT    0   arithmetic right shift applied to sum before ReLU/sat
//  RELU_EN      1   1: clamp negatives to 0; 0: signed pass with saturation
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  clr        in   1      sync clear: idx:=0, pipeline valids:=0
//  in_valid   in   1      accumulator valid
//  in_ready   out  1      stage can accept
//  in_acc     in   ACC_W  signed accumulator
//  in_last    in   1      marks last neuron of frame
//  rom_ce     out  1      bias ROM read enable
//  rom_oce    out  1      = rom_ce
//  rom_reset  out  1      tied 0
//  rom_ad     out  5      bias ROM address = current idx
//  rom_dout   in   16     signed bias, valid 1 clk after rom_ce
//  out_valid  out  1      activation valid
//  out_ready  in   1      downstream accepts
//  out_data   out  16     activation (signed Q as accumulator >> OUT_SHIFT)
//  out_idx    out  5      neuron index of out_data
//  out_last   out  1      out_idx == NUM_NEURONS-1
//  frame_err  out  1      1-clk pulse on frame/index mismatch
// BEHAVIOUR
//  - Reset (rst_n=0, async): idx, all valids, out_data, out_idx, out_last,
//    frame_err, rom_ce := 0. in_ready=1 first cycle after release.
//  - Pipeline: S1 (acc, idx, v1), S2 = output regs (out_*, out_valid).
//    accept = in_valid & in_ready; on accept: rom_ce=1 with rom_ad=idx,
//    S1 captures in_acc/idx; next cycle rom_dout holds bias.
//  - adv2 = ~out_valid | out_ready; adv1 = v1 & adv2.
//    in_ready = ~v1 | adv2 (combinational, no in_valid dependence).
//  - rom_ce asserted only on accept, so rom_dout stays stable while S1 stalls.
//  - Latency: accept at T -> out_valid at T+2 with no backpressure;
//    throughput 1/clk sustained. No loss/duplication under any stall pattern.
//  - Arithmetic: sum(ACC_W+1+BIAS_SHIFT bits) = sext(acc) + (sext(bias)<<BIAS_SHIFT);
//    sh = sum >>> OUT_SHIFT; RELU_EN & sh<0 -> 0; sh>32767 -> 16'h7FFF;
//    sh<-32768 -> 16'h8000 (reachable only when RELU_EN=0). Never wraps.
//  - idx: increments on accept; after NUM_NEURONS-1 wraps to 0.
//    in_last at idx!=NUM_NEURONS-1 -> frame_err pulse, idx:=0 (resync).
//    idx==NUM_NEURONS-1 without in_last -> frame_err pulse, idx:=0.
//    frame_err asserted the cycle after the offending accept.
//  - clr takes priority over accept in same cycle; accept dropped, in_ready
//    stays 1. Mid-frame rst_n/clr discards in-flight items.
// TESTING
//  1 rst_n low mid-stream -> all outputs 0 immediately; after release idx=0,
//    first accept reads rom_ad=0.
//  2 ROM[0]=16'hFEA5(-347); acc=1000 at idx0 -> out_data=653, out_idx=0 at T+2;
//    acc=100 at idx0 -> out_data=0 (ReLU).
//  3 ROM[1]=16'h0151; acc=32'h7FFFFFFF at idx1 -> out_data=16'h7FFF, no wrap;
//    RELU_EN=0, acc=32'h80000000 -> 16'h8000.
//  4 30 back-to-back accepts, out_ready=1, in_last on 30th -> 30 outputs on
//    consecutive clks, rom_ad 0..29, out_last only on 30th, frame_err=0.
//  5 out_ready low 5 clks mid-stream -> in_ready falls after 2 held items,
//    rom_ce=0 during stall, sequence intact vs. reference model.
//  6 in_last at idx5 -> frame_err 1 clk, next accept uses rom_ad=0; clr
//    coincident with accept -> accept dropped, idx=0.

Source files
------------

// File: rtl/fc_bias_relu.sv
// Fully-connected layer output stage: per-neuron bias add from ROM, ReLU and 16-bit
// saturation, behind a two-stage valid/ready pipeline with frame index tracking.
module fc_bias_relu #(
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned BIAS_SHIFT  = 0,
  parameter int unsigned OUT_SHIFT   = 0,
  parameter bit          RELU_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  input  logic             in_last,
  output logic             rom_ce,
  output logic             rom_oce,
  output logic             rom_reset,
  output logic [4:0]       rom_ad,
  input  logic [15:0]      rom_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             frame_err
);

  localparam int unsigned SumW = ACC_W + 1 + BIAS_SHIFT;
  localparam logic [4:0] LastIdx = 5'(NUM_NEURONS - 1);
  localparam logic signed [SumW-1:0] SatMax = SumW'(32767);
  localparam logic signed [SumW-1:0] SatMin = -(SumW'(32768));

  logic [4:0]       idx_q, idx_d;
  logic             ferr_d;
  logic             v1_q;
  logic [ACC_W-1:0] acc1_q;
  logic [4:0]       idx1_q;
  logic             adv1, adv2, accept, at_last;

  logic signed [SumW-1:0] sum, sh;
  logic [15:0]            act;

  assign adv2      = ~out_valid | out_ready;
  assign adv1      = v1_q & adv2;
  assign in_ready  = ~v1_q | adv2;
  assign accept    = in_valid & in_ready & ~clr;
  // ROM is only read on accept so its output holds steady while S1 is stalled.
  assign rom_ce    = accept;
  assign rom_oce   = rom_ce;
  assign rom_reset = 1'b0;
  assign rom_ad    = idx_q;
  assign at_last   = (idx_q == LastIdx);

  // A framing mismatch in either direction resynchronises the index to 0.
  always_comb begin
    idx_d  = idx_q;
    ferr_d = 1'b0;
    if (accept) begin
      if (in_last != at_last) begin
        ferr_d = 1'b1;
        idx_d  = '0;
      end else if (at_last) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end
  end

  always_comb begin
    sum = $signed({{(SumW-ACC_W){acc1_q[ACC_W-1]}}, acc1_q})
        + ($signed({{(SumW-16){rom_dout[15]}}, rom_dout}) <<< BIAS_SHIFT);
    sh  = sum >>> OUT_SHIFT;
    act = sh[15:0];
    if (RELU_EN && sh[SumW-1]) begin
      act = '0;
    end else if (sh > SatMax) begin
      act = 16'h7fff;
    end else if (sh < SatMin) begin
      act = 16'h8000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      frame_err <= 1'b0;
    end else if (clr) begin
      idx_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      frame_err <= ferr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      acc1_q <= '0;
      idx1_q <= '0;
    end else if (clr) begin
      v1_q <= 1'b0;
    end else if (accept) begin
      v1_q   <= 1'b1;
      acc1_q <= in_acc;
      idx1_q <= idx_q;
    end else if (adv1) begin
      v1_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (adv1) begin
      out_valid <= 1'b1;
      out_data  <= act;
      out_idx   <= idx1_q;
      out_last  <= (idx1_q == LastIdx);
    end else if (adv2) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fc_bias_relu.sv
// Bench for fc_bias_relu: a ReLU and a pass-through instance share stimulus and
// are compared against an expected-output queue built from plain arithmetic.
`timescale 1ns/1ps
module tb_fc_bias_relu;
  localparam int N  = 30;
  localparam int BS = 0;
  localparam int OS = 0;

  logic        clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_acc = '0;

  logic        in_ready, rom_ce, rom_oce, rom_reset, out_valid, out_last, frame_err;
  logic [4:0]  rom_ad, out_idx;
  logic [15:0] rom_dout, out_data;
  logic        in_ready2, rom_ce2, rom_oce2, rom_reset2, out_valid2, out_last2, frame_err2;
  logic [4:0]  rom_ad2, out_idx2;
  logic [15:0] rom_dout2, out_data2;

  logic [15:0] rom [32];

  typedef struct {
    logic [15:0] d;
    logic [15:0] d2;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   m_idx, checks, failures, n_fire, n_last, f0, l0;
  bit   ferr_cur, ferr_nxt;

  fc_bias_relu #(.NUM_NEURONS(N), .ACC_W(32), .BIAS_SHIFT(BS), .OUT_SHIFT(OS), .RELU_EN(1'b1))
  dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_last(in_last), .rom_ce(rom_ce), .rom_oce(rom_oce),
    .rom_reset(rom_reset), .rom_ad(rom_ad), .rom_dout(rom_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .frame_err(frame_err)
  );

  fc_bias_relu #(.NUM_NEURONS(N), .ACC_W(32), .BIAS_SHIFT(BS), .OUT_SHIFT(OS), .RELU_EN(1'b0))
  dut_lin (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_acc(in_acc), .in_last(in_last), .rom_ce(rom_ce2), .rom_oce(rom_oce2),
    .rom_reset(rom_reset2), .rom_ad(rom_ad2), .rom_dout(rom_dout2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
    .frame_err(frame_err2)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rom_ce)  rom_dout  <= rom[rom_ad];
    if (rom_ce2) rom_dout2 <= rom[rom_ad2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_act(input logic [31:0] acc, input logic [15:0] bias,
                                          input bit relu);
    longint s;
    s = longint'($signed(acc)) + (longint'($signed(bias)) <<< BS);
    s = s >>> OS;
    if (relu && s < 0) return 16'h0000;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [31:0] rand_acc();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 80000)) - 32'd40000;
  endfunction

  // One clock: observe at the falling edge, update the model, return 1ns after the rise.
  task automatic cyc(input int exp_rdy = -1);
    exp_t e;
    @(negedge clk);
    ferr_nxt = 1'b0;
    chk("frame_err", 32'(frame_err), 32'(ferr_cur));
    chk("frame_err_lin", 32'(frame_err2), 32'(ferr_cur));
    if (exp_rdy >= 0) chk("in_ready", 32'(in_ready), exp_rdy);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 0);
      end else begin
        e = q[0];
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_data_lin", 32'(out_data2), 32'(e.d2));
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
        if (out_ready) begin
          void'(q.pop_front());
          n_fire++;
          if (out_last) n_last++;
        end
      end
    end
    if (clr) begin
      chk("rom_ce_clr", 32'(rom_ce), 0);
      q.delete();
      m_idx = 0;
    end else if (in_valid && in_ready) begin
      chk("rom_ce_acc", 32'(rom_ce), 1);
      chk("rom_ad", 32'(rom_ad), m_idx);
      e.d    = ref_act(in_acc, rom[m_idx], 1'b1);
      e.d2   = ref_act(in_acc, rom[m_idx], 1'b0);
      e.idx  = 5'(m_idx);
      e.last = (m_idx == N - 1);
      q.push_back(e);
      if (in_last != (m_idx == N - 1)) begin
        ferr_nxt = 1'b1;
        m_idx    = 0;
      end else begin
        m_idx = (m_idx + 1) % N;
      end
    end else begin
      chk("rom_ce_idle", 32'(rom_ce), 0);
    end
    @(posedge clk);
    #1;
    ferr_cur = ferr_nxt;
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    clr      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_rom_ce", 32'(rom_ce), 0);
    chk("rst_rom_oce", 32'(rom_oce), 0);
    chk("rst_rom_reset", 32'(rom_reset), 0);
    chk("rst_rom_ad", 32'(rom_ad), 0);
    q.delete();
    m_idx    = 0;
    ferr_cur = 1'b0;
    ferr_nxt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    rom[0] = 16'hfea5;
    rom[1] = 16'h0151;

    reset_pulse();

    // Bias add, two-cycle latency, then ReLU clamp.
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = 32'd1000; in_last = 1'b0;
    cyc(1);
    chk("lat_t1_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
    cyc();
    chk("lat_t2_valid", 32'(out_valid), 1);
    chk("lat_t2_data", 32'(out_data), 653);
    chk("lat_t2_idx", 32'(out_idx), 0);
    cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    in_valid = 1'b1; in_acc = 32'd100;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("relu_valid", 32'(out_valid), 1);
    chk("relu_data", 32'(out_data), 0);
    cyc();

    // Saturation in both directions.
    clr = 1'b1; cyc(); clr = 1'b0;
    in_valid = 1'b1; in_acc = 32'h8000_0000;
    cyc();
    in_acc = 32'h7fff_ffff;
    cyc();
    in_valid = 1'b0;
    chk("sat_neg_relu", 32'(out_data), 32'h0000);
    chk("sat_neg_lin", 32'(out_data2), 32'h8000);
    cyc();
    chk("sat_pos_relu", 32'(out_data), 32'h7fff);
    chk("sat_pos_lin", 32'(out_data2), 32'h7fff);
    cyc();

    // Full back-to-back frame.
    clr = 1'b1; cyc(); clr = 1'b0;
    f0 = n_fire; l0 = n_last;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_acc = rand_acc(); in_last = (i == N - 1);
      cyc(1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("burst_fires_during", n_fire - f0, N - 2);
    repeat (2) cyc();
    chk("burst_fires_total", n_fire - f0, N);
    chk("burst_last_count", n_last - l0, 1);

    // Downstream stall for five cycles mid-stream.
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_acc = rand_acc(); in_last = (m_idx == N - 1);
      out_ready = !(i >= 10 && i < 15);
      if (i >= 10 && i < 15) cyc(0);
      else cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("stall_drained", q.size(), 0);

    // Early in_last resync, clr beating accept, missing in_last.
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_acc = rand_acc(); in_last = (i == 5);
      cyc();
    end
    in_last = 1'b0;
    chk("early_last_ferr", 32'(frame_err), 1);
    chk("early_last_resync", 32'(rom_ad), 0);
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_drop_idx", 32'(rom_ad), 0);
    chk("clr_in_ready", 32'(in_ready), 1);
    cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_acc = rand_acc(); in_last = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
    chk("missing_last_ferr", 32'(frame_err), 1);
    cyc();

    // Random traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_acc    = rand_acc();
      in_last   = (m_idx == N - 1) ^ ($urandom_range(0, 40) == 0);
      clr       = ($urandom_range(0, 60) == 0);
      cyc();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("final_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
